// File: rtl/compositor_pkg.sv
// compositor_pkg: shared types and constants for the layer compositor.
//   - pixel/timing widths (RGB_W, HC_W, VC_W)
//   - layer_cfg_t   : per-layer enable and priority entry
//   - timing_t      : bundled VGA timing signals carried down the pipeline
//   - cfg_state_t   : configuration commit FSM states
//   - debug palette colours used when COMPOSITOR_SEL_DEBUG_EN is defined
package compositor_pkg;

  localparam int unsigned RGB_W      = 12;
  localparam int unsigned HC_W       = 11;
  localparam int unsigned VC_W       = 10;
  // Priority storage width; the configured PRIO_W is zero-extended into it.
  localparam int unsigned PRIO_MAX_W = 8;

  localparam logic [RGB_W-1:0] RGB_BLACK = '0;

  localparam logic [RGB_W-1:0] DBG_RGB_L0 = 12'hF00;
  localparam logic [RGB_W-1:0] DBG_RGB_L1 = 12'h0F0;
  localparam logic [RGB_W-1:0] DBG_RGB_L2 = 12'h00F;
  localparam logic [RGB_W-1:0] DBG_RGB_L3 = 12'hFF0;
  localparam logic [RGB_W-1:0] DBG_RGB_HI = 12'hFFF;

  typedef struct packed {
    logic                  en;
    logic [PRIO_MAX_W-1:0] prio;
  } layer_cfg_t;

  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [VC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } timing_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } cfg_state_t;

  function automatic logic [RGB_W-1:0] debug_colour(input int unsigned idx);
    case (idx)
      0:       return DBG_RGB_L0;
      1:       return DBG_RGB_L1;
      2:       return DBG_RGB_L2;
      3:       return DBG_RGB_L3;
      default: return DBG_RGB_HI;
    endcase
  endfunction

endpackage

// File: rtl/compositor_cfg_shadow.sv
// compositor_cfg_shadow: layer configuration tables and frame bookkeeping.
//   Config writes land in a shadow table; the shadow is copied to the active
//   table in a single COMMIT cycle after the first vblank rise following a
//   write, so each frame is drawn with one consistent configuration.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   vblnk_in            raw vertical blank, edge-detected here
//   cfg_valid/cfg_ready config write handshake
//   cfg_layer/en/prio   config write payload
//   cfg_pending         high while the shadow holds uncommitted writes
//   act_tbl             table the select datapath samples
//   frame_cnt           vblank-rise counter, wraps at 16 bits
import compositor_pkg::*;

module compositor_cfg_shadow #(
  parameter int unsigned N_LAYERS = 4,
  parameter int unsigned PRIO_W   = 2,
  localparam int unsigned LAYER_W = $clog2(N_LAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vblnk_in,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [LAYER_W-1:0]             cfg_layer,
  input  logic                           cfg_en,
  input  logic [PRIO_W-1:0]              cfg_prio,
  output logic                           cfg_pending,
  output layer_cfg_t [N_LAYERS-1:0]      act_tbl,
  output logic [15:0]                    frame_cnt
);

  cfg_state_t                state_q,  state_d;
  layer_cfg_t [N_LAYERS-1:0] shadow_q, shadow_d;
  layer_cfg_t [N_LAYERS-1:0] active_q, active_d;
  logic                      vblnk_q,  vblnk_d;
  logic [15:0]               fcnt_q,   fcnt_d;

  logic vblank_rise;
  logic wr_acc;
  logic wr_hit;

  function automatic layer_cfg_t reset_entry(input int unsigned i);
    layer_cfg_t e;
    e.en   = 1'b1;
    e.prio = PRIO_MAX_W'(i % (32'd1 << PRIO_W));
    return e;
  endfunction

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    vblnk_d  = vblnk_in;
    fcnt_d   = fcnt_q;

    vblank_rise = vblnk_in & ~vblnk_q;
    wr_acc      = cfg_valid & (state_q != COMMIT);
    // Out-of-range layers are handshaken but leave all state untouched.
    wr_hit      = wr_acc & (32'(cfg_layer) < N_LAYERS);

    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      if (wr_hit && (cfg_layer == LAYER_W'(i))) begin
        shadow_d[i].en   = cfg_en;
        shadow_d[i].prio = PRIO_MAX_W'(cfg_prio);
      end
    end

    if (vblank_rise) begin
      fcnt_d = fcnt_q + 16'd1;
    end

    case (state_q)
      IDLE:    if (wr_hit) state_d = PENDING;
      PENDING: if (vblank_rise) state_d = COMMIT;
      COMMIT: begin
        active_d = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vblnk_q <= 1'b0;
      fcnt_q  <= '0;
      for (int unsigned i = 0; i < N_LAYERS; i++) begin
        shadow_q[i] <= reset_entry(i);
        active_q[i] <= reset_entry(i);
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      vblnk_q  <= vblnk_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign cfg_ready   = (state_q != COMMIT);
  assign cfg_pending = (state_q == PENDING);
  // During COMMIT the pixel sampled this cycle already sees the new table,
  // so the shadow is forwarded ahead of the active register update.
  assign act_tbl     = (state_q == COMMIT) ? shadow_q : active_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: rtl/layer_compositor_ctrl.sv
// layer_compositor_ctrl: per-pixel layer arbiter for the VGA frame.
//   Two-stage pipeline: S1 registers timing, layer colours and candidate
//   flags (enabled & opaque, sampled against the active table); S2 picks the
//   highest-priority candidate (ties to lowest index) and registers rgb,
//   selected layer and timing. Blanking forces black, no candidate gives
//   BG_RGB. sel_layer_out MSB=1 flags background or blank.
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   hcount/vcount/sync/blnk  timing in, delayed by 2 cycles on *_out
//   layer_rgb_in             layer i colour at [12i+11:12i]
//   layer_opaque_in          layer i draws at this pixel
//   cfg_*                    valid/ready layer config write port
//   rgb_out, sel_layer_out   composited pixel and winning layer
//   cfg_pending_out          shadow table awaiting commit at vblank
//   frame_cnt_out            frame counter, aligned with timing outputs
// Build option: define COMPOSITOR_SEL_DEBUG_EN to replace rgb_out with a fixed
//   palette colour identifying the winning layer.
import compositor_pkg::*;

module layer_compositor_ctrl #(
  parameter int unsigned      N_LAYERS = 4,
  parameter int unsigned      PRIO_W   = 2,
  parameter logic [RGB_W-1:0] BG_RGB   = 12'h888,
  localparam int unsigned     LAYER_W  = $clog2(N_LAYERS),
  localparam int unsigned     SEL_W    = LAYER_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HC_W-1:0]           hcount_in,
  input  logic [VC_W-1:0]           vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [RGB_W*N_LAYERS-1:0] layer_rgb_in,
  input  logic [N_LAYERS-1:0]       layer_opaque_in,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [LAYER_W-1:0]        cfg_layer,
  input  logic                      cfg_en,
  input  logic [PRIO_W-1:0]         cfg_prio,
  output logic [HC_W-1:0]           hcount_out,
  output logic [VC_W-1:0]           vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [RGB_W-1:0]          rgb_out,
  output logic [SEL_W-1:0]          sel_layer_out,
  output logic                      cfg_pending_out,
  output logic [15:0]               frame_cnt_out
);

  localparam logic [SEL_W-1:0] SEL_NONE = {1'b1, {LAYER_W{1'b0}}};

  layer_cfg_t [N_LAYERS-1:0] act_tbl;
  logic [15:0]               frame_cnt;

  compositor_cfg_shadow #(
    .N_LAYERS (N_LAYERS),
    .PRIO_W   (PRIO_W)
  ) u_cfg_shadow (
    .clk         (clk),
    .rst         (rst),
    .vblnk_in    (vblnk_in),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_layer   (cfg_layer),
    .cfg_en      (cfg_en),
    .cfg_prio    (cfg_prio),
    .cfg_pending (cfg_pending_out),
    .act_tbl     (act_tbl),
    .frame_cnt   (frame_cnt)
  );

  // S1 state
  timing_t                                s1_tim_q,  s1_tim_d;
  logic [N_LAYERS-1:0][RGB_W-1:0]         s1_rgb_q,  s1_rgb_d;
  logic [N_LAYERS-1:0]                    s1_cand_q, s1_cand_d;
  logic [N_LAYERS-1:0][PRIO_MAX_W-1:0]    s1_prio_q, s1_prio_d;
  // Cleared by reset so the first post-reset S2 output is blank, not BG_RGB.
  logic                                   s1_vld_q,  s1_vld_d;

  // S2 state
  timing_t          tim_q,  tim_d;
  logic [RGB_W-1:0] rgb_q,  rgb_d;
  logic [SEL_W-1:0] sel_q,  sel_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic                  win_found;
  logic [LAYER_W-1:0]    win_idx;
  logic [PRIO_MAX_W-1:0] win_prio;
  logic                  blank;

  always_comb begin
    s1_tim_d = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    s1_rgb_d = layer_rgb_in;
    s1_vld_d = 1'b1;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      s1_cand_d[i] = act_tbl[i].en & layer_opaque_in[i];
      s1_prio_d[i] = act_tbl[i].prio;
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    // Ascending scan with strict '>' keeps the lowest index on a tie.
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      if (s1_cand_q[i] && (!win_found || (s1_prio_q[i] > win_prio))) begin
        win_found = 1'b1;
        win_idx   = LAYER_W'(i);
        win_prio  = s1_prio_q[i];
      end
    end

    blank  = ~s1_vld_q | s1_tim_q.hblnk | s1_tim_q.vblnk;
    tim_d  = s1_tim_q;
    fcnt_d = frame_cnt;

    if (blank) begin
      rgb_d = RGB_BLACK;
      sel_d = SEL_NONE;
    end else if (!win_found) begin
`ifdef COMPOSITOR_SEL_DEBUG_EN
      rgb_d = RGB_BLACK;
`else
      rgb_d = BG_RGB;
`endif
      sel_d = SEL_NONE;
    end else begin
`ifdef COMPOSITOR_SEL_DEBUG_EN
      rgb_d = debug_colour(32'(win_idx));
`else
      rgb_d = s1_rgb_q[win_idx];
`endif
      sel_d = {1'b0, win_idx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tim_q  <= '0;
      s1_rgb_q  <= '0;
      s1_cand_q <= '0;
      s1_prio_q <= '0;
      s1_vld_q  <= 1'b0;
      tim_q     <= '0;
      rgb_q     <= '0;
      sel_q     <= SEL_NONE;
      fcnt_q    <= '0;
    end else begin
      s1_tim_q  <= s1_tim_d;
      s1_rgb_q  <= s1_rgb_d;
      s1_cand_q <= s1_cand_d;
      s1_prio_q <= s1_prio_d;
      s1_vld_q  <= s1_vld_d;
      tim_q     <= tim_d;
      rgb_q     <= rgb_d;
      sel_q     <= sel_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign hcount_out    = tim_q.hcount;
  assign vcount_out    = tim_q.vcount;
  assign hsync_out     = tim_q.hsync;
  assign vsync_out     = tim_q.vsync;
  assign hblnk_out     = tim_q.hblnk;
  assign vblnk_out     = tim_q.vblnk;
  assign rgb_out       = rgb_q;
  assign sel_layer_out = sel_q;
  assign frame_cnt_out = fcnt_q;

endmodule

// File: tb/tb_layer_compositor_ctrl.sv
// Scoreboard bench for layer_compositor_ctrl: the driver applies stimulus at
// each falling edge, updates a frame-level reference model and queues the
// expected pixel (2 cycles later) and config-port state (1 cycle later); a
// monitor checks the DUT shortly after each rising edge.
import compositor_pkg::*;

module tb_layer_compositor_ctrl;

  localparam int N      = 4;
  localparam int PRIO_W = 2;
  localparam logic [11:0] BG = 12'h888;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [10:0]       hcount_in = '0;
  logic [9:0]        vcount_in = '0;
  logic              hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [12*N-1:0]   layer_rgb_in = '0;
  logic [N-1:0]      layer_opaque_in = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_layer = '0;
  logic              cfg_en = 1'b0;
  logic [PRIO_W-1:0] cfg_prio = '0;
  logic [10:0]       hcount_out;
  logic [9:0]        vcount_out;
  logic              hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]       rgb_out;
  logic [2:0]        sel_layer_out;
  logic              cfg_pending_out;
  logic [15:0]       frame_cnt_out;

  layer_compositor_ctrl #(.N_LAYERS(N), .PRIO_W(PRIO_W), .BG_RGB(BG)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .layer_rgb_in(layer_rgb_in), .layer_opaque_in(layer_opaque_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_en(cfg_en), .cfg_prio(cfg_prio),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .sel_layer_out(sel_layer_out),
    .cfg_pending_out(cfg_pending_out), .frame_cnt_out(frame_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [11:0] rgb;
    logic [2:0]  sel;
    timing_t     tim;
    logic [15:0] fcnt;
  } pix_exp_t;

  typedef struct {
    int unsigned due;
    logic ready;
    logic pending;
  } cfg_exp_t;

  pix_exp_t pixq[$];
  cfg_exp_t cfgq[$];
  int unsigned pcnt = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always @(posedge clk) pcnt++;

  // Reference model: frame-level view of the configuration.
  bit          m_en[N];
  int          m_pr[N];
  bit          s_en[N];
  int          s_pr[N];
  bit          m_pending;
  bit          m_commit;   // the cycle following a committing vblank rise
  bit          m_vprev;
  logic [15:0] m_fcnt;
  bit          last_acc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 1'b1; s_en[i] = 1'b1;
      m_pr[i] = i % (1 << PRIO_W); s_pr[i] = m_pr[i];
    end
    m_pending = 1'b0; m_commit = 1'b0; m_vprev = 1'b0; m_fcnt = '0;
  endtask

  function automatic int winner(input bit en[N], input int pr[N], input logic [N-1:0] op);
    for (int p = (1 << PRIO_W) - 1; p >= 0; p--)
      for (int i = 0; i < N; i++)
        if (en[i] && op[i] && pr[i] == p) return i;
    return -1;
  endfunction

  function automatic pix_exp_t blank_exp(input int unsigned due);
    pix_exp_t e;
    e.due = due; e.rgb = '0; e.sel = 3'b100; e.tim = '0; e.fcnt = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, pcnt, act, exp);
    end
  endtask

  // Called at a falling edge with the inputs already applied; records the
  // expectations these inputs imply, then advances to the next falling edge.
  task automatic step();
    pix_exp_t pe;
    cfg_exp_t ce;
    bit       acc, rise, en_u[N];
    int       pr_u[N];
    int       w;
    if (rst) begin
      if (pixq.size() > 0 && pixq[pixq.size()-1].due == pcnt + 1)
        pixq[pixq.size()-1] = blank_exp(pcnt + 1);
      pe = blank_exp(pcnt + 2);
      model_reset();
      last_acc = 1'b0;
    end else begin
      if (m_commit) begin en_u = s_en; pr_u = s_pr; end
      else begin en_u = m_en; pr_u = m_pr; end
      w = winner(en_u, pr_u, layer_opaque_in);
      pe.due = pcnt + 2;
      pe.tim = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      if (hblnk_in || vblnk_in) begin
        pe.rgb = '0; pe.sel = 3'b100;
      end else if (w < 0) begin
`ifdef COMPOSITOR_SEL_DEBUG_EN
        pe.rgb = '0;
`else
        pe.rgb = BG;
`endif
        pe.sel = 3'b100;
      end else begin
`ifdef COMPOSITOR_SEL_DEBUG_EN
        pe.rgb = debug_colour(w);
`else
        pe.rgb = layer_rgb_in[w*12 +: 12];
`endif
        pe.sel = 3'(w);
      end
      acc  = cfg_valid && !m_commit;
      rise = vblnk_in && !m_vprev;
      if (m_commit) begin
        m_en = s_en; m_pr = s_pr; m_commit = 1'b0;
      end else begin
        if (acc) begin s_en[cfg_layer] = cfg_en; s_pr[cfg_layer] = int'(cfg_prio); end
        if (m_pending && rise) begin m_commit = 1'b1; m_pending = 1'b0; end
        else if (acc) m_pending = 1'b1;
      end
      if (rise) m_fcnt = m_fcnt + 16'd1;
      m_vprev  = vblnk_in;
      last_acc = acc;
      pe.fcnt  = m_fcnt;
    end
    ce.due = pcnt + 1; ce.ready = !m_commit; ce.pending = m_pending;
    pixq.push_back(pe);
    cfgq.push_back(ce);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write1(input logic [1:0] l, input logic e, input logic [PRIO_W-1:0] p);
    cfg_valid = 1'b1; cfg_layer = l; cfg_en = e; cfg_prio = p;
    step();
    cfg_valid = 1'b0;
  endtask

  // Monitor
  initial begin
    pix_exp_t pe;
    cfg_exp_t ce;
    forever begin
      @(posedge clk); #1;
      while (pixq.size() > 0 && pixq[0].due <= pcnt) begin
        pe = pixq.pop_front();
        if (pe.due != pcnt) chk("pix_missed", pe.due, pcnt);
        else begin
          chk("rgb_out", 32'(rgb_out), 32'(pe.rgb));
          chk("sel_layer_out", 32'(sel_layer_out), 32'(pe.sel));
          chk("timing_out", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(pe.tim));
          chk("frame_cnt_out", 32'(frame_cnt_out), 32'(pe.fcnt));
        end
      end
      while (cfgq.size() > 0 && cfgq[0].due <= pcnt) begin
        ce = cfgq.pop_front();
        if (ce.due != pcnt) chk("cfg_missed", ce.due, pcnt);
        else begin
          chk("cfg_ready", 32'(cfg_ready), 32'(ce.ready));
          chk("cfg_pending_out", 32'(cfg_pending_out), 32'(ce.pending));
        end
      end
    end
  end

  // Driver
  initial begin
    int rst_cnt;
    model_reset();
    last_acc = 1'b0;
    @(negedge clk);
    steps(3);
    rst = 1'b0;

    // Defaults: all opaque, layer 3 has the highest priority.
    layer_rgb_in    = {12'h400, 12'h300, 12'h200, 12'h100};
    layer_opaque_in = 4'hF;
    hcount_in = 11'd100; vcount_in = 10'd20;
    steps(4);

    // Tie at prio 3 between layers 1 and 3, committed at the next vblank.
    write1(2'd1, 1'b1, 2'd3);
    write1(2'd3, 1'b1, 2'd3);
    steps(2);
    vblnk_in = 1'b1; steps(3);
    vblnk_in = 1'b0; steps(3);
    layer_opaque_in = 4'h0; steps(2);

    // Blanking overrides an opaque layer.
    layer_opaque_in = 4'b0100; hblnk_in = 1'b1; steps(2);
    hblnk_in = 1'b0; layer_opaque_in = 4'hF;

    // Deferred commit of a disable.
    write1(2'd3, 1'b0, 2'd3);
    steps(4);
    vblnk_in = 1'b1; steps(2);
    vblnk_in = 1'b0; steps(3);

    // Write coincident with vblank rise, then valid held through COMMIT.
    write1(2'd0, 1'b1, 2'd0);
    steps(2);
    vblnk_in = 1'b1;
    cfg_valid = 1'b1; cfg_layer = 2'd2; cfg_en = 1'b1; cfg_prio = 2'd3;
    step();
    cfg_layer = 2'd1; cfg_en = 1'b0; cfg_prio = 2'd1;
    steps(2);
    cfg_valid = 1'b0;
    vblnk_in = 1'b0; steps(3);

    // Reset while PENDING.
    write1(2'd2, 1'b0, 2'd0);
    steps(2);
    rst = 1'b1; steps(2);
    rst = 1'b0; steps(4);

    // Randomized traffic.
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_cnt == 0 && $urandom_range(0, 699) == 0) rst_cnt = $urandom_range(1, 3);
      rst = (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      if ($urandom_range(0, 15) == 0) vblnk_in = ~vblnk_in;
      hblnk_in  = ($urandom_range(0, 7) == 0);
      hcount_in = 11'($urandom);
      vcount_in = 10'($urandom);
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
      layer_rgb_in    = {$urandom, $urandom};
      layer_opaque_in = 4'($urandom);
      if (rst || !cfg_valid || last_acc) begin
        cfg_valid = !rst && ($urandom_range(0, 5) == 0);
        cfg_layer = 2'($urandom);
        cfg_en    = ($urandom_range(0, 3) != 0);
        cfg_prio  = PRIO_W'($urandom);
      end
      step();
    end
    rst = 1'b0; cfg_valid = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(pixq.size() + cfgq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
